hr_16t4_tx_sched: RTL and testbench

Transmit word scheduler for the half-rate 16:4 serializer path. It runs on the word clock produced by the serializer's divide-by-2. Each cycle it drives the 16-bit parallel word (`tx_word`) that feeds the 16:4 mux `din`. It sequences link bring-up (idle, then a fixed training burst, then payload) and selects the payload source: buffered user data via valid/ready, an internal PRBS7, or a static configuration pattern.

---
 rtl/hr_16t4_tx_sched.sv | 158 +++++++++++++++
 tb/tb_hr_16t4_tx_sched.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/hr_16t4_tx_sched.sv
// Transmit word scheduler for the half-rate 16:4 serializer: IDLE -> TRAIN -> RUN bring-up,
// payload from user FIFO, PRBS7 or a static pattern. Optional PRBS7 generator: TX_SCHED_PRBS_EN.
module hr_16t4_tx_sched #(
  parameter int          TRAIN_WORDS = 64,
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [15:0] IDLE_WORD   = 16'h0000,
  parameter logic [15:0] TRAIN_PAT   = 16'h5555
) (
  input  logic        clk_prbs,
  input  logic        rst,
  input  logic        en,
  input  logic [1:0]  mode,
  input  logic [15:0] cfg_pat,
  input  logic [15:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [15:0] tx_word,
  output logic [1:0]  state,
  output logic        train_done,
  output logic [7:0]  underflow_cnt
);

  localparam int CW = $clog2(TRAIN_WORDS + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int NW = AW + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_TRAIN = 2'b01,
    ST_RUN   = 2'b10
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   tcnt_q, tcnt_d;
  logic [15:0]     tx_q, tx_d;
  logic [7:0]      uf_q;
  logic [15:0]     mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wptr_q, rptr_q;
  logic [NW-1:0]   cnt_q;
  logic            full, empty, wr, pop, uf_inc, last_train, payload;

  // Handshake: a word transfers on any edge where s_valid && s_ready; s_ready depends only on
  // registered state (not IDLE, FIFO not full), so a pop in the same cycle never frees a slot early.
  assign full       = (cnt_q == NW'(FIFO_DEPTH));
  assign empty      = (cnt_q == '0);
  assign s_ready    = (state_q != ST_IDLE) && !full;
  assign wr         = s_valid && s_ready;
  assign last_train = (tcnt_q == CW'(TRAIN_WORDS));
  // The cycle after the last training word already carries payload, so RUN starts with it.
  assign payload    = en && ((state_q == ST_RUN) || ((state_q == ST_TRAIN) && last_train));
  assign pop        = payload && (mode == 2'b00) && !empty;
  assign uf_inc     = payload && (mode == 2'b00) && empty;

`ifdef TX_SCHED_PRBS_EN
  logic [6:0] lfsr_q, lfsr_d;

  // Sixteen Fibonacci steps of x^7+x^6+1; result is {next_lfsr, word}, word bit 0 first in time.
  function automatic logic [22:0] prbs_step(input logic [6:0] seed);
    logic [6:0]  s;
    logic [15:0] w;
    logic        b;
    s = seed;
    w = '0;
    for (int k = 0; k < 16; k++) begin
      b    = s[6] ^ s[5];
      w[k] = b;
      s    = {s[5:0], b};
    end
    return {s, w};
  endfunction
`endif

  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    tx_d    = IDLE_WORD;
`ifdef TX_SCHED_PRBS_EN
    lfsr_d  = (state_q == ST_IDLE) ? 7'h7F : lfsr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        tcnt_d = '0;
        if (en) state_d = ST_TRAIN;
      end
      ST_TRAIN: begin
        if (!en) begin
          state_d = ST_IDLE;
        end else if (!last_train) begin
          tx_d   = tcnt_q[0] ? ~TRAIN_PAT : TRAIN_PAT;
          tcnt_d = tcnt_q + CW'(1);
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!en) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (payload) begin
      case (mode)
        2'b00: if (!empty) tx_d = mem_q[rptr_q];
        2'b10: tx_d = cfg_pat;
`ifdef TX_SCHED_PRBS_EN
        2'b01: {lfsr_d, tx_d} = prbs_step(lfsr_q);
`endif
        default: tx_d = IDLE_WORD;
      endcase
    end
  end

  always_ff @(posedge clk_prbs) begin
    if (rst) begin
      state_q <= ST_IDLE;
      tcnt_q  <= '0;
      tx_q    <= IDLE_WORD;
      uf_q    <= '0;
`ifdef TX_SCHED_PRBS_EN
      lfsr_q  <= 7'h7F;
`endif
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      tx_q    <= tx_d;
      if (uf_inc && (uf_q != 8'hFF)) uf_q <= uf_q + 8'd1;
`ifdef TX_SCHED_PRBS_EN
      lfsr_q  <= lfsr_d;
`endif
    end
  end

  // FIFO pointers; IDLE holds the buffer empty so stale words never survive a re-enable.
  always_ff @(posedge clk_prbs) begin
    if (rst || (state_q == ST_IDLE)) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (wr)  wptr_q <= wptr_q + AW'(1);
      if (pop) rptr_q <= rptr_q + AW'(1);
      case ({wr, pop})
        2'b10:   cnt_q <= cnt_q + NW'(1);
        2'b01:   cnt_q <= cnt_q - NW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_prbs) begin
    if (wr) mem_q[wptr_q] <= s_data;
  end

  assign tx_word       = tx_q;
  assign state         = state_q;
  assign train_done    = (state_q == ST_RUN);
  assign underflow_cnt = uf_q;

endmodule

// File: tb/tb_hr_16t4_tx_sched.sv
// Bench for hr_16t4_tx_sched: directed bring-up steps plus random traffic, checked every cycle
// against a transaction-level model (queue FIFO, precomputed PRBS7 bit stream).
module tb_hr_16t4_tx_sched;
  localparam int TW = 4;
  localparam int FD = 4;

  logic        clk_prbs = 1'b0;
  logic        rst, en, s_valid;
  logic [1:0]  mode;
  logic [15:0] cfg_pat, s_data;
  logic        s_ready, train_done;
  logic [15:0] tx_word;
  logic [1:0]  state;
  logic [7:0]  underflow_cnt;

  int total = 0;
  int bad   = 0;

  hr_16t4_tx_sched #(.TRAIN_WORDS(TW), .FIFO_DEPTH(FD)) dut (
    .clk_prbs(clk_prbs), .rst(rst), .en(en), .mode(mode), .cfg_pat(cfg_pat),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .tx_word(tx_word),
    .state(state), .train_done(train_done), .underflow_cnt(underflow_cnt)
  );

  // clock/reset block
  always #5 clk_prbs = ~clk_prbs;

  // reference model: 0 idle, 1 train, 2 run
  int          m_state = 0;
  int          m_tcnt  = 0;
  int          m_uf    = 0;
  int          m_pidx  = 0;
  logic [15:0] m_tx    = 16'h0000;
  bit          m_acc   = 1'b0;
  bit          prbs_bits [127];
  logic [15:0] exp_q [$];

  function automatic logic [15:0] prbs_word(input int idx);
    logic [15:0] w;
    for (int k = 0; k < 16; k++) w[k] = prbs_bits[(idx + k) % 127];
    return w;
  endfunction

  task automatic payload_word(output logic [15:0] w);
    w = 16'h0000;
    case (mode)
      2'b00: begin
        if (exp_q.size() > 0) w = exp_q.pop_front();
        else if (m_uf < 255) m_uf++;
      end
      2'b01: begin
`ifdef TX_SCHED_PRBS_EN
        w      = prbs_word(m_pidx);
        m_pidx = (m_pidx + 16) % 127;
`endif
      end
      2'b10: w = cfg_pat;
      default: w = 16'h0000;
    endcase
  endtask

  task automatic model_step();
    logic [15:0] out;
    bit          ready;
    out   = 16'h0000;
    m_acc = 1'b0;
    if (rst) begin
      m_state = 0; m_tcnt = 0; m_uf = 0; m_pidx = 0; m_tx = 16'h0000;
      exp_q.delete();
      return;
    end
    ready = (m_state != 0) && (exp_q.size() < FD);
    m_acc = s_valid && ready;
    case (m_state)
      0: begin
        exp_q.delete();
        m_tcnt = 0;
        m_pidx = 0;
        if (en) m_state = 1;
      end
      1: begin
        if (!en) m_state = 0;
        else if (m_tcnt < TW) begin
          out = (m_tcnt % 2 == 1) ? 16'hAAAA : 16'h5555;
          m_tcnt++;
        end else begin
          payload_word(out);
          m_state = 2;
        end
      end
      default: begin
        if (!en) m_state = 0;
        else payload_word(out);
      end
    endcase
    if (m_acc) exp_q.push_back(s_data);
    m_tx = out;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // driver: one clock, advance the model, then check all outputs away from the edge
  task automatic cyc();
    @(posedge clk_prbs);
    model_step();
    #1;
    chk("tx_word", tx_word, m_tx);
    chk("state", {14'b0, state}, 16'(m_state));
    chk("train_done", {15'b0, train_done}, {15'b0, m_state == 2});
    chk("s_ready", {15'b0, s_ready}, {15'b0, (m_state != 0) && (exp_q.size() < FD)});
    chk("underflow_cnt", {8'b0, underflow_cnt}, 16'(m_uf));
  endtask

  initial begin
    logic [6:0] s;
    bit         b;
    int         n;
    s = 7'h7F;
    for (int i = 0; i < 127; i++) begin
      b            = s[6] ^ s[5];
      prbs_bits[i] = b;
      s            = {s[5:0], b};
    end

    rst = 1'b1; en = 1'b0; mode = 2'b00; cfg_pat = 16'h0000; s_data = 16'h0000; s_valid = 1'b0;
    repeat (2) cyc();
    rst = 1'b0;
    repeat (10) cyc();

    // bring-up into static pattern
    mode = 2'b10; cfg_pat = 16'hC3C3; en = 1'b1;
    repeat (12) cyc();
    en = 1'b0;
    repeat (3) cyc();

    // user mode with preload during training, then underflow
    mode = 2'b00; en = 1'b1; s_data = 16'h0001; s_valid = 1'b1; n = 0;
    repeat (20) begin
      cyc();
      if (m_acc) begin
        n++;
        s_data = s_data + 16'h0001;
        if (n == 4) s_valid = 1'b0;
      end
    end

    // random user traffic with occasional mode changes
    repeat (80) begin
      s_valid = 1'($urandom_range(0, 1));
      s_data  = 16'($urandom);
      if ($urandom_range(0, 9) == 0) mode = 2'($urandom_range(0, 3));
      cyc();
    end

    // PRBS7 long run, then restart after re-enable
    s_valid = 1'b0; mode = 2'b01; en = 1'b0;
    repeat (2) cyc();
    en = 1'b1;
    repeat (TW + 2 + 256) cyc();
    en = 1'b0;
    repeat (2) cyc();
    en = 1'b1;
    repeat (TW + 2 + 40) cyc();

    // reset with three buffered words
    mode = 2'b10; s_valid = 1'b1; n = 0;
    while (n < 3) begin
      s_data = 16'($urandom);
      cyc();
      if (m_acc) n++;
    end
    s_valid = 1'b0; rst = 1'b1;
    cyc();
    rst = 1'b0; mode = 2'b00;
    repeat (12) cyc();

    // fully random phase
    repeat (300) begin
      rst     = ($urandom_range(0, 99) == 0);
      en      = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 7) == 0) mode = 2'($urandom_range(0, 3));
      cfg_pat = ($urandom_range(0, 15) == 0) ? 16'($urandom) : cfg_pat;
      s_valid = 1'($urandom_range(0, 1));
      s_data  = 16'($urandom);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
